imm_gen_pipe_rv: RTL and testbench

Registered, parametrised immediate generator for the RV decode stage. It extracts and sign- or zero-extends immediates from instr[31:7] for XLEN 32 or 64. It adds CSR-uimm and shift-amount formats to the base I/S/B/U/J set. A two-entry valid/ready skid pipeline sits between instruction decode and the execute operand mux, with a synchronous flush for branch redirects.

---
 rtl/imm_gen_pipe_rv_pkg.sv | 33 +++
 rtl/imm_gen_pipe_rv_extract.sv | 54 +++++
 rtl/imm_gen_pipe_rv.sv | 138 +++++++++++++
 tb/tb_imm_gen_pipe_rv.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pipe_rv_pkg.sv
// imm_pkg: shared encodings for the RV immediate generator pipeline.
// Holds the immediate-format codes, the skid-pipeline state encoding
// and the datapath-width legality check used at elaboration.
package imm_pkg;

  // Number of instruction bits presented to the generator (instr[31:7]).
  localparam int IMM_INSTR_W = 25;

  // Immediate format selector as driven by decode.
  typedef enum logic [2:0] {
    IMM_I   = 3'd0,
    IMM_S   = 3'd1,
    IMM_B   = 3'd2,
    IMM_U   = 3'd3,
    IMM_J   = 3'd4,
    IMM_Z   = 3'd5,
    IMM_SH  = 3'd6,
    IMM_RSV = 3'd7
  } imm_type_e;

  // Occupancy of the OUT register plus the single skid entry.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

  // Only RV32 and RV64 datapaths are supported.
  function automatic bit xlen_legal(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_gen_pipe_rv_extract.sv
// imm_extract: combinational immediate decoder for instr[31:7].
// Bit k of the architectural instruction sits at instr_i[k-7].
// Optional macro IMM_GEN_ERR_EN adds err_o for reserved/illegal formats.
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [IMM_INSTR_W-1:0] instr_i,
  input  logic [2:0]             immtype_i,
  output logic [XLEN-1:0]        imm_o
`ifdef IMM_GEN_ERR_EN
  ,
  output logic                   err_o
`endif
);

  logic [XLEN-1:0] u_s;
  logic [XLEN-1:0] sh_s;

  // U and SH formats differ between RV32 and RV64.
  if (XLEN == 64) begin : g_x64
    assign u_s  = {{32{instr_i[24]}}, instr_i[24:5], 12'd0};
    assign sh_s = {{(XLEN-6){1'b0}}, instr_i[18:13]};
  end else begin : g_x32
    assign u_s  = {instr_i[24:5], 12'd0};
    assign sh_s = {{(XLEN-5){1'b0}}, instr_i[17:13]};
  end

  // Select and extend the immediate for the requested format.
  always_comb begin
    imm_o = '0;
    case (imm_type_e'(immtype_i))
      IMM_I:   imm_o = {{(XLEN-12){instr_i[24]}}, instr_i[24:13]};
      IMM_S:   imm_o = {{(XLEN-12){instr_i[24]}}, instr_i[24:18], instr_i[4:0]};
      IMM_B:   imm_o = {{(XLEN-12){instr_i[24]}}, instr_i[0], instr_i[23:18],
                        instr_i[4:1], 1'b0};
      IMM_U:   imm_o = u_s;
      IMM_J:   imm_o = {{(XLEN-20){instr_i[24]}}, instr_i[12:5], instr_i[13],
                        instr_i[23:14], 1'b0};
      IMM_Z:   imm_o = {{(XLEN-5){1'b0}}, instr_i[12:8]};
      IMM_SH:  imm_o = sh_s;
      IMM_RSV: imm_o = '0;
      default: imm_o = '0;
    endcase
  end

`ifdef IMM_GEN_ERR_EN
  // Reserved code, or a 6-bit shamt on an RV32 datapath (instr[25] set).
  assign err_o = (immtype_i == IMM_RSV) ||
                 ((immtype_i == IMM_SH) && (XLEN == 32) && instr_i[18]);
`endif

endmodule

// File: rtl/imm_gen_pipe_rv.sv
// imm_gen_pipe_rv: registered immediate generator with a two-entry
// valid/ready skid pipeline (OUT register + one SKID entry) and a
// synchronous flush for branch redirects.
// Optional macro IMM_GEN_ERR_EN adds the per-beat out_err flag.
module imm_gen_pipe_rv
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IMM_INSTR_W-1:0] in_instr,
  input  logic [2:0]             in_immtype,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_imm,
  output logic [TAG_W-1:0]       out_tag
`ifdef IMM_GEN_ERR_EN
  ,
  output logic                   out_err
`endif
);

  if (!xlen_legal(XLEN)) begin : g_xlen_check
    $error("imm_gen_pipe_rv: XLEN must be 32 or 64");
  end

  // One buffered beat: immediate, sideband tag and (optionally) error flag.
  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
`ifdef IMM_GEN_ERR_EN
    logic             err;
`endif
  } entry_t;

  entry_t          entry_d;
  entry_t          out_q;
  entry_t          skid_q;
  pipe_state_e     state_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            acc_s;
  logic            pop_s;
  logic [XLEN-1:0] imm_s;
`ifdef IMM_GEN_ERR_EN
  logic            err_s;
`endif

  imm_extract #(
    .XLEN (XLEN)
  ) u_extract (
    .instr_i   (in_instr),
    .immtype_i (in_immtype),
    .imm_o     (imm_s)
`ifdef IMM_GEN_ERR_EN
    ,
    .err_o     (err_s)
`endif
  );

  // Handshakes: a beat offered during flush is never accepted.
  assign acc_s = in_valid && in_ready_q && !flush;
  assign pop_s = out_valid_q && out_ready;

  // Pack the freshly decoded beat into an entry.
  always_comb begin
    entry_d     = '0;
    entry_d.imm = imm_s;
    entry_d.tag = in_tag;
`ifdef IMM_GEN_ERR_EN
    entry_d.err = err_s;
`endif
  end

  // Occupancy FSM with OUT/SKID storage and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      out_q       <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc_s) begin
            out_q       <= entry_d;
            state_q     <= ST_ONE;
            out_valid_q <= 1'b1;
          end
        end
        ST_ONE: begin
          if (acc_s && !pop_s) begin
            skid_q     <= entry_d;
            state_q    <= ST_TWO;
            in_ready_q <= 1'b0;
          end else if (acc_s && pop_s) begin
            out_q <= entry_d;
          end else if (pop_s) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        ST_TWO: begin
          if (pop_s) begin
            out_q      <= skid_q;
            state_q    <= ST_ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_imm   = out_q.imm;
  assign out_tag   = out_q.tag;
`ifdef IMM_GEN_ERR_EN
  assign out_err   = out_q.err;
`endif

endmodule

// File: tb/tb_imm_gen_pipe_rv.sv
// Self-checking bench: RV32 and RV64 instances share stimulus; a queue
// model computes immediates arithmetically from the full instruction word.
module tb_imm_gen_pipe_rv;

  localparam int TAG_W = 8;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, out_ready;
  logic [24:0]      in_instr;
  logic [2:0]       in_immtype;
  logic [TAG_W-1:0] in_tag;
  logic             rdy32, rdy64, v32, v64;
  logic [31:0]      imm32;
  logic [63:0]      imm64;
  logic [TAG_W-1:0] tag32, tag64;
  logic             err32, err64;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0]      i64;
    logic [31:0]      i32;
    logic [TAG_W-1:0] tag;
    logic             e32;
    logic             e64;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  imm_gen_pipe_rv #(.XLEN(32), .TAG_W(TAG_W)) u_dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_immtype(in_immtype), .in_tag(in_tag),
    .out_valid(v32), .out_ready(out_ready), .out_imm(imm32), .out_tag(tag32)
`ifdef IMM_GEN_ERR_EN
    , .out_err(err32)
`endif
  );

  imm_gen_pipe_rv #(.XLEN(64), .TAG_W(TAG_W)) u_dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_immtype(in_immtype), .in_tag(in_tag),
    .out_valid(v64), .out_ready(out_ready), .out_imm(imm64), .out_tag(tag64)
`ifdef IMM_GEN_ERR_EN
    , .out_err(err64)
`endif
  );

`ifndef IMM_GEN_ERR_EN
  assign err32 = 1'b0;
  assign err64 = 1'b0;
`endif

  task automatic check_eq(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference immediate from the whole 32-bit word, plain arithmetic.
  function automatic logic [63:0] ref_imm(input logic [31:0] w, input logic [2:0] t, input int xl);
    longint sw;
    longint v;
    sw = $signed(w);
    case (t)
      3'd0: v = sw >>> 20;
      3'd1: v = ((sw >>> 25) <<< 5) | longint'((w >> 7) & 32'd31);
      3'd2: begin
        v = longint'((((w >> 7) & 32'd1) << 11) | (((w >> 25) & 32'd63) << 5) |
                     (((w >> 8) & 32'd15) << 1));
        if (w[31]) v = v - 64'sd4096;
      end
      3'd3: v = sw & ~64'sd4095;
      3'd4: begin
        v = longint'((((w >> 12) & 32'd255) << 12) | (((w >> 20) & 32'd1) << 11) |
                     (((w >> 21) & 32'd1023) << 1));
        if (w[31]) v = v - 64'sd1048576;
      end
      3'd5: v = longint'((w >> 15) & 32'd31);
      3'd6: v = longint'((w >> 20) & ((xl == 64) ? 32'd63 : 32'd31));
      default: v = 64'sd0;
    endcase
    return v;
  endfunction

  function automatic logic ref_err(input logic [31:0] w, input logic [2:0] t, input int xl);
`ifdef IMM_GEN_ERR_EN
    return (t == 3'd7) || ((t == 3'd6) && (xl == 32) && w[25]);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_outputs();
    check_eq("valid32", v32, q.size() > 0);
    check_eq("valid64", v64, q.size() > 0);
    check_eq("ready32", rdy32, q.size() < 2);
    check_eq("ready64", rdy64, q.size() < 2);
    if (q.size() > 0) begin
      check_eq("imm32", imm32, q[0].i32);
      check_eq("imm64", imm64, q[0].i64);
      check_eq("tag32", tag32, q[0].tag);
      check_eq("tag64", tag64, q[0].tag);
      check_eq("err32", err32, q[0].e32);
      check_eq("err64", err64, q[0].e64);
    end
  endtask

  // One clock: drive inputs, advance the model, sample on the falling edge.
  task automatic step(input logic v, input logic [31:0] w, input logic [2:0] t,
                      input logic [TAG_W-1:0] tg, input logic rdy, input logic fl,
                      input logic rs);
    logic acc, pop;
    logic [63:0] r64;
    exp_t e;
    in_valid   = v;
    in_instr   = w[31:7];
    in_immtype = t;
    in_tag     = tg;
    out_ready  = rdy;
    flush      = fl;
    rst        = rs;
    acc = v && (q.size() < 2) && !fl && !rs;
    pop = (q.size() > 0) && rdy;
    if (rs || fl) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        r64   = ref_imm(w, t, 64);
        e.i64 = r64;
        r64   = ref_imm(w, t, 32);
        e.i32 = r64[31:0];
        e.tag = tg;
        e.e32 = ref_err(w, t, 32);
        e.e64 = ref_err(w, t, 64);
        q.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    logic [31:0] rw;
    // Reset state.
    step(1'b0, 32'd0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'd0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    check_eq("rst_imm64", imm64, 64'd0);
    check_eq("rst_tag32", tag32, 64'd0);
    check_eq("rst_err32", err32, 64'd0);

    // Known-answer formats, streaming with out_ready=1.
    step(1'b1, 32'hFFF00093, 3'd0, 8'h11, 1'b1, 1'b0, 1'b0);
    check_eq("kat_I", imm32, 64'hFFFFFFFF);
    step(1'b1, 32'hFE000EE3, 3'd2, 8'h12, 1'b1, 1'b0, 1'b0);
    check_eq("kat_B", imm32, 64'hFFFFFFFC);
    step(1'b1, 32'h0080006F, 3'd4, 8'h13, 1'b1, 1'b0, 1'b0);
    check_eq("kat_J", imm32, 64'h00000008);
    step(1'b1, 32'h800000B7, 3'd3, 8'h14, 1'b1, 1'b0, 1'b0);
    check_eq("kat_U64", imm64, 64'hFFFFFFFF80000000);
    step(1'b1, 32'h000F8000, 3'd5, 8'h15, 1'b1, 1'b0, 1'b0);
    check_eq("kat_Z", imm32, 64'h1F);
    step(1'b0, 32'd0, 3'd0, 8'd0, 1'b1, 1'b0, 1'b0);

    // Backpressure: A, B accepted, C held upstream until drained.
    step(1'b1, 32'h00100093, 3'd0, 8'hA0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h00200093, 3'd0, 8'hB0, 1'b0, 1'b0, 1'b0);
    check_eq("bp_ready_low", rdy32, 64'd0);
    step(1'b1, 32'h00300093, 3'd0, 8'hC0, 1'b0, 1'b0, 1'b0);
    check_eq("bp_hold_A", tag32, 64'hA0);
    step(1'b1, 32'h00300093, 3'd0, 8'hC0, 1'b1, 1'b0, 1'b0);
    check_eq("bp_out_B", tag32, 64'hB0);
    step(1'b1, 32'h00300093, 3'd0, 8'hC0, 1'b1, 1'b0, 1'b0);
    check_eq("bp_out_C", tag32, 64'hC0);
    step(1'b0, 32'd0, 3'd0, 8'd0, 1'b1, 1'b0, 1'b0);

    // Flush in state TWO with a beat offered.
    step(1'b1, 32'h00100093, 3'd0, 8'hD0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h00200093, 3'd0, 8'hD1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h00300093, 3'd0, 8'hD2, 1'b1, 1'b1, 1'b0);
    check_eq("fl_valid", v32, 64'd0);
    check_eq("fl_ready", rdy32, 64'd1);
    step(1'b0, 32'd0, 3'd0, 8'd0, 1'b1, 1'b0, 1'b0);
    check_eq("fl_dropped", v64, 64'd0);

`ifdef IMM_GEN_ERR_EN
    step(1'b1, 32'hFFFFFFFF, 3'd7, 8'hE0, 1'b0, 1'b0, 1'b0);
    check_eq("rsv_imm", imm32, 64'd0);
    check_eq("rsv_err", err32, 64'd1);
    step(1'b0, 32'd0, 3'd0, 8'd0, 1'b1, 1'b0, 1'b0);
`endif

    // Reset while stalled in TWO.
    step(1'b1, 32'h00100093, 3'd0, 8'hF0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h00200093, 3'd0, 8'hF1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h00300093, 3'd0, 8'hF2, 1'b0, 1'b0, 1'b1);
    check_eq("rst_stall_ready", rdy64, 64'd1);
    check_eq("rst_stall_imm", imm32, 64'd0);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      rw = $urandom;
      step(($urandom_range(3) != 0), rw, 3'($urandom_range(7)), 8'($urandom_range(255)),
           ($urandom_range(2) != 0), ($urandom_range(19) == 0), ($urandom_range(96) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
